// File: rtl/verificador_pin_param.sv
// verificador_pin_param: PIN entry/verification FSM for the automatic cashier.
// Collects DIGITS BCD digits after card insertion, compares them against the
// stored PIN, counts failed attempts, warns before the last try and locks out.
// Optional feature macro: PIN_TIMEOUT_EN (inter-digit inactivity timeout).
module verificador_pin_param #(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned MAX_INTENTOS = 3,
   parameter int unsigned TIMEOUT_CYC  = 1000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tarjeta_recibida,
   input  logic                  digito_stb,
   input  logic [3:0]            digito,
   input  logic [4*DIGITS-1:0]   pin_correcto,
   input  logic                  desbloqueo,
   output logic                  pin_incorrecto,
   output logic                  advertencia,
   output logic                  bloqueo,
   output logic                  fin,
   output logic                  timeout
);

   localparam int unsigned PW = 4 * DIGITS;
   localparam int unsigned CW = 4;
   localparam int unsigned FW = 4;

   // Reject out-of-range configurations at elaboration time.
   if (DIGITS < 2 || DIGITS > 8 || MAX_INTENTOS < 2 || MAX_INTENTOS > 15 ||
       TIMEOUT_CYC < 1) begin : g_bad_params
      $error("verificador_pin_param: parameter out of range");
   end

   typedef enum logic [2:0] {
      IDLE,
      RECIBIENDO,
      VERIFICAR,
      TRANSACCION,
      BLOQUEO
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   pin_q;
   logic [PW-1:0]   pin_d;
   logic [CW-1:0]   dcnt_q;
   logic [CW-1:0]   dcnt_d;
   logic [FW-1:0]   fail_q;
   logic [FW-1:0]   fail_d;
   logic            pin_incorrecto_q;
   logic            advertencia_q;
   logic            bloqueo_q;
   logic            fin_q;
   logic            digit_ok_c;
   logic            match_c;

`ifdef PIN_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0]   tmo_q;
   logic            timeout_q;
`endif

   // Datapath helpers: digit acceptance, shifted PIN, next counts, compare.
   always_comb begin
      digit_ok_c = digito_stb && (digito <= 4'd9);
      pin_d      = {pin_q[PW-5:0], digito};
      dcnt_d     = dcnt_q + CW'(1);
      fail_d     = (fail_q == FW'(MAX_INTENTOS)) ? fail_q : fail_q + FW'(1);
      match_c    = (pin_q == pin_correcto);
   end

   // Main FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         pin_q            <= '0;
         dcnt_q           <= '0;
         fail_q           <= '0;
         pin_incorrecto_q <= 1'b0;
         advertencia_q    <= 1'b0;
         bloqueo_q        <= 1'b0;
         fin_q            <= 1'b0;
`ifdef PIN_TIMEOUT_EN
         tmo_q            <= '0;
         timeout_q        <= 1'b0;
`endif
      end else begin
         pin_incorrecto_q <= 1'b0;
         fin_q            <= 1'b0;
`ifdef PIN_TIMEOUT_EN
         timeout_q        <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (tarjeta_recibida) begin
                  state_q <= RECIBIENDO;
                  dcnt_q  <= '0;
                  pin_q   <= '0;
`ifdef PIN_TIMEOUT_EN
                  tmo_q   <= '0;
`endif
               end
            end
            RECIBIENDO: begin
               if (digit_ok_c) begin
                  pin_q  <= pin_d;
                  dcnt_q <= dcnt_d;
`ifdef PIN_TIMEOUT_EN
                  tmo_q  <= '0;
`endif
                  if (dcnt_d == CW'(DIGITS)) begin
                     state_q <= VERIFICAR;
                  end
               end
`ifdef PIN_TIMEOUT_EN
               // An accepted digit in the expiry cycle has priority over expiry.
               else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                  timeout_q <= 1'b1;
                  state_q   <= IDLE;
                  dcnt_q    <= '0;
                  pin_q     <= '0;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
`endif
            end
            VERIFICAR: begin
               if (match_c) begin
                  fail_q        <= '0;
                  advertencia_q <= 1'b0;
                  fin_q         <= 1'b1;
                  state_q       <= TRANSACCION;
               end else begin
                  pin_incorrecto_q <= 1'b1;
                  fail_q           <= fail_d;
                  if (fail_d == FW'(MAX_INTENTOS)) begin
                     state_q       <= BLOQUEO;
                     bloqueo_q     <= 1'b1;
                     advertencia_q <= 1'b0;
                  end else begin
                     if (fail_d == FW'(MAX_INTENTOS - 1)) begin
                        advertencia_q <= 1'b1;
                     end
                     state_q <= RECIBIENDO;
                     dcnt_q  <= '0;
                     pin_q   <= '0;
`ifdef PIN_TIMEOUT_EN
                     tmo_q   <= '0;
`endif
                  end
               end
            end
            TRANSACCION: begin
               state_q <= IDLE;
            end
            BLOQUEO: begin
               if (desbloqueo) begin
                  state_q   <= IDLE;
                  fail_q    <= '0;
                  bloqueo_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign pin_incorrecto = pin_incorrecto_q;
   assign advertencia    = advertencia_q;
   assign bloqueo        = bloqueo_q;
   assign fin            = fin_q;
`ifdef PIN_TIMEOUT_EN
   assign timeout        = timeout_q;
`else
   assign timeout        = 1'b0;
`endif

endmodule
